dtw_ref_streamer: RTL and testbench
===================================

DTW_REF_STREAMER -- requirements
Module: dtw_ref_streamer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, reference sample width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, reference address and length width.
REQ-003 SHALL have port clk_in  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_in  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start_in  input  1  single-cycle pulse requesting one streaming pass.
REQ-006 SHALL have port abort_in  input  1  flush the current pass and return to idle.
REQ-007 SHALL have port ref_len_in  input  ADDR_WIDTH  number of samples to stream.
REQ-008 SHALL have port ref_load_done_in  input  1  reference memory holds a valid reference.
REQ-009 SHALL have port ref_addr_out  output  ADDR_WIDTH  read address to the reference memory.
REQ-010 SHALL have port ref_data_in  input  DATA_WIDTH  memory read data, valid one cycle after its address.
REQ-011 SHALL have port ref_valid_out  output  1  output beat valid.
REQ-012 SHALL have port ref_ready_in  input  1  downstream ready; a beat transfers when valid and ready are both 1.
REQ-013 SHALL have port ref_data_out  output  DATA_WIDTH  output sample.
REQ-014 SHALL have port ref_last_out  output  1  marks beat index ref_len-1.
REQ-015 SHALL have port busy_out  output  1  pass in progress.
REQ-016 SHALL have port done_out  output  1  single-cycle pulse at pass completion.
REQ-017 SHALL have port dbg_state  output  2  current FSM state.

Function
REQ-018 SHALL implement FSM states IDLE=0, STREAM=1, DRAIN=2. Encoding 3 is unreachable and SHALL return to IDLE.
REQ-019 In IDLE, start_in=1 with ref_load_done_in=1 and ref_len_in!=0 SHALL latch ref_len_in, clear the address counter, and go to STREAM.
REQ-020 In IDLE, start_in=1 with ref_load_done_in=0 SHALL be ignored.
REQ-021 In IDLE, start_in=1 with ref_load_done_in=1 and ref_len_in=0 SHALL pulse done_out on the next cycle and emit no beats.
REQ-022 start_in outside IDLE SHALL be ignored. Changes to ref_len_in during a pass SHALL have no effect.
REQ-023 In STREAM, an address SHALL issue when (buffered beats + in-flight reads) < 2. ref_addr_out then increments from 0 to len-1, one per issue.
REQ-024 Read data SHALL be captured into a 2-entry output buffer the cycle after issue. The buffer SHALL never overflow or drop a sample.
REQ-025 With ref_ready_in held at 1, the block SHALL sustain 1 beat per cycle. ref_valid_out SHALL first assert in the 3rd cycle after the cycle in which start_in is sampled.
REQ-026 While ref_valid_out=1 and ref_ready_in=0, ref_data_out and ref_last_out SHALL hold stable.
REQ-027 After issuing address len-1, the FSM SHALL go to DRAIN.
REQ-028 In DRAIN, the handshake of the last beat SHALL pulse done_out in the following cycle and return the FSM to IDLE.
REQ-029 busy_out SHALL be 1 in STREAM and DRAIN and 0 in IDLE.
REQ-030 abort_in=1 in any state SHALL, on the next cycle, empty the buffer, clear ref_valid_out, enter IDLE, and not pulse done_out. Read data returning after an abort SHALL be discarded.
REQ-031 The address counter and the beat counter SHALL be ADDR_WIDTH wide. A length of 2^ADDR_WIDTH-1 SHALL stream with no wrap-around.

Reset
REQ-032 rst_in=1 SHALL force state IDLE and the buffer empty. ref_addr_out, ref_valid_out, ref_data_out, ref_last_out, busy_out, done_out and dbg_state SHALL all be 0.
REQ-033 Reset asserted mid-pass SHALL behave as abort, with all outputs at reset values on the next cycle.

Structure
REQ-034 Package dtw_pkg SHALL hold the FSM state constants and the default DATA_WIDTH/ADDR_WIDTH values.
REQ-035 The 2-entry output buffer SHALL be a sub-module named dtw_ref_skid_buf with push, pop, full/empty flags, and a data+last payload.

Verification
REQ-036 Stimulus: len=4, memory[i]=0x100+i, ready held 1. Required response: beats 0x100..0x103 on consecutive cycles; last only on 0x103; one done_out pulse one cycle after the final beat.
REQ-037 Stimulus: len=8, ready toggled 1,0,0,1,... Required response: all 8 samples delivered in order, none duplicated or dropped; data stable while stalled; at most 2 beats buffered.
REQ-038 Stimulus: start with ref_load_done_in=0. Required response: state stays IDLE, busy_out=0, no beats. Stimulus: start with len=0. Required response: done_out pulses once and no beats.
REQ-039 Stimulus: len=16, abort_in pulsed after 5 beats, then a new start with len=2. Required response: valid drops the next cycle with no done_out; the second pass emits memory[0], memory[1] with last on the second.
REQ-040 Stimulus: rst_in asserted during STREAM with ready=0. Required response: all outputs 0 on the next cycle; a subsequent start with len=3 streams correctly.
REQ-041 Stimulus: start_in pulsed during STREAM with a different ref_len_in. Required response: the pulse is ignored and the original length completes.

Source files
------------

// File: rtl/dtw_pkg.sv
// dtw_pkg: shared constants for the DTW reference streamer.
package dtw_pkg;

    // Default widths for reference samples and for addresses/lengths.
    localparam int DTW_DATA_WIDTH = 16;
    localparam int DTW_ADDR_WIDTH = 32;

    // Streamer FSM encoding; 2'd3 is unused and falls back to idle.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    // A pass is in progress whenever the FSM is streaming or draining.
    function automatic logic state_busy(input logic [1:0] st);
        return (st == ST_STREAM) || (st == ST_DRAIN);
    endfunction

endpackage

// File: rtl/dtw_ref_streamer_if.sv
// dtw_ref_streamer_if: reference-memory read bus plus the outgoing sample stream.
interface dtw_ref_streamer_if
    import dtw_pkg::*;
#(
    parameter int DATA_WIDTH = DTW_DATA_WIDTH,
    parameter int ADDR_WIDTH = DTW_ADDR_WIDTH
) ();

    logic [ADDR_WIDTH-1:0] ref_addr_out;
    logic [DATA_WIDTH-1:0] ref_data_in;
    logic                  ref_valid_out;
    logic                  ref_ready_in;
    logic [DATA_WIDTH-1:0] ref_data_out;
    logic                  ref_last_out;

    // The streamer drives addresses and beats; memory and the consumer drive the rest.
    modport master (
        output ref_addr_out,
        input  ref_data_in,
        output ref_valid_out,
        input  ref_ready_in,
        output ref_data_out,
        output ref_last_out
    );

    modport slave (
        input  ref_addr_out,
        output ref_data_in,
        input  ref_valid_out,
        output ref_ready_in,
        input  ref_data_out,
        input  ref_last_out
    );

endinterface

// File: rtl/dtw_ref_skid_buf.sv
// dtw_ref_skid_buf: two-entry FIFO holding sample+last; entry 0 is always the head.
module dtw_ref_skid_buf
    import dtw_pkg::*;
#(
    parameter int DATA_WIDTH = DTW_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  push_last,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_last,
    output logic                  full,
    output logic                  empty,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] data0;
    logic [DATA_WIDTH-1:0] data1;
    logic                  last0;
    logic                  last1;
    logic [1:0]            level;
    logic                  do_push;
    logic                  do_pop;

    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign do_pop  = pop && (level != 2'd0);
    assign do_push = push && ((level != 2'd2) || do_pop);

    assign head_data = data0;
    assign head_last = last0;
    assign full      = (level == 2'd2);
    assign empty     = (level == 2'd0);
    assign count     = level;

    // Shift the second entry forward on pop and land new data in the first free slot.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            level <= 2'd0;
            data0 <= '0;
            last0 <= 1'b0;
            data1 <= '0;
            last1 <= 1'b0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (level == 2'd0) begin
                        data0 <= push_data;
                        last0 <= push_last;
                    end else begin
                        data1 <= push_data;
                        last1 <= push_last;
                    end
                    level <= level + 2'd1;
                end
                2'b01: begin
                    data0 <= data1;
                    last0 <= last1;
                    level <= level - 2'd1;
                end
                2'b11: begin
                    if (level == 2'd1) begin
                        data0 <= push_data;
                        last0 <= push_last;
                    end else begin
                        data0 <= data1;
                        last0 <= last1;
                        data1 <= push_data;
                        last1 <= push_last;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/dtw_ref_streamer.sv
// dtw_ref_streamer: reads ref_len samples from reference memory and streams them
// out over a valid/ready handshake, one beat per cycle when the consumer keeps up.
module dtw_ref_streamer
    import dtw_pkg::*;
#(
    parameter int DATA_WIDTH = DTW_DATA_WIDTH,
    parameter int ADDR_WIDTH = DTW_ADDR_WIDTH
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    input  logic                  abort_in,
    input  logic [ADDR_WIDTH-1:0] ref_len_in,
    input  logic                  ref_load_done_in,
    dtw_ref_streamer_if.master    bus,
    output logic                  busy_out,
    output logic                  done_out,
    output logic [1:0]            dbg_state
);

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] len_q;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [ADDR_WIDTH-1:0] beat_cnt;
    logic                  inflight;
    logic                  inflight_last;

    logic [DATA_WIDTH-1:0] buf_data;
    logic                  buf_last;
    logic                  buf_full;
    logic                  buf_empty;
    logic [1:0]            buf_count;

    logic                  pop;
    logic                  push;
    logic [1:0]            occupancy;
    logic                  issue;
    logic                  at_last_addr;
    logic                  last_handshake;

    assign pop  = !buf_empty && bus.ref_ready_in;
    assign push = inflight && (!buf_full || pop);

    // Occupancy counts the beat leaving this cycle as already gone so that a
    // consumer holding ready high sees back-to-back beats.
    assign occupancy      = buf_count - {1'b0, pop} + {1'b0, inflight};
    assign issue          = (state == ST_STREAM) && (occupancy < 2'd2);
    assign at_last_addr   = (addr_cnt == len_q - ADDR_WIDTH'(1));
    assign last_handshake = pop && (beat_cnt == len_q - ADDR_WIDTH'(1));

    assign bus.ref_addr_out  = addr_cnt;
    assign bus.ref_valid_out = !buf_empty;
    assign bus.ref_data_out  = buf_data;
    assign bus.ref_last_out  = buf_last;
    assign busy_out          = state_busy(state);
    assign dbg_state         = state;

    dtw_ref_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid_buf (
        .clk       (clk_in),
        .rst       (rst_in),
        .flush     (abort_in),
        .push      (push),
        .push_data (bus.ref_data_in),
        .push_last (inflight_last),
        .pop       (pop),
        .head_data (buf_data),
        .head_last (buf_last),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    // Pass control: latch the length, walk the address counter, and retire on the last beat.
    always_ff @(posedge clk_in) begin
        if (rst_in || abort_in) begin
            state         <= ST_IDLE;
            addr_cnt      <= '0;
            beat_cnt      <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done_out      <= 1'b0;
            if (rst_in) begin
                len_q <= '0;
            end
        end else begin
            done_out      <= 1'b0;
            inflight      <= issue;
            inflight_last <= issue && at_last_addr;
            if (pop) begin
                beat_cnt <= beat_cnt + ADDR_WIDTH'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (start_in && ref_load_done_in) begin
                        if (ref_len_in == '0) begin
                            done_out <= 1'b1;
                        end else begin
                            len_q    <= ref_len_in;
                            addr_cnt <= '0;
                            beat_cnt <= '0;
                            state    <= ST_STREAM;
                        end
                    end
                end
                ST_STREAM: begin
                    if (issue) begin
                        if (at_last_addr) begin
                            state <= ST_DRAIN;
                        end else begin
                            addr_cnt <= addr_cnt + ADDR_WIDTH'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (last_handshake) begin
                        done_out <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dtw_ref_streamer.sv
// tb_dtw_ref_streamer: directed and randomized passes checked against a sample-list model.
module tb_dtw_ref_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_in;
    logic        abort_in;
    logic [31:0] ref_len_in;
    logic        ref_load_done_in;
    logic        busy_out;
    logic        done_out;
    logic [1:0]  dbg_state;

    logic [15:0] mem [0:63];

    int checks   = 0;
    int failures = 0;

    dtw_ref_streamer_if #(.DATA_WIDTH(16), .ADDR_WIDTH(32)) bus ();

    dtw_ref_streamer #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (32)
    ) dut (
        .clk_in           (clk),
        .rst_in           (rst),
        .start_in         (start_in),
        .abort_in         (abort_in),
        .ref_len_in       (ref_len_in),
        .ref_load_done_in (ref_load_done_in),
        .bus              (bus),
        .busy_out         (busy_out),
        .done_out         (done_out),
        .dbg_state        (dbg_state)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Reference memory: read data appears the cycle after the address.
    always @(posedge clk) begin
        bus.ref_data_in <= mem[bus.ref_addr_out[5:0]];
    end

    // Hard stop if something wedges despite the per-pass budgets.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic pick_ready(input int mode, input int cyc);
        case (mode)
            0: return 1'b1;
            1: return ((cyc % 4) == 0) || ((cyc % 4) == 3);
            2: return ($urandom_range(0, 1) == 1);
            default: return 1'b0;
        endcase
    endfunction

    task automatic check_quiet(input string tag, input logic exp_done);
        check_output({tag, "_valid"}, 64'(bus.ref_valid_out), 64'(0));
        check_output({tag, "_busy"},  64'(busy_out),          64'(0));
        check_output({tag, "_state"}, 64'(dbg_state),         64'(0));
        check_output({tag, "_done"},  64'(done_out),          64'(exp_done));
    endtask

    // One pass: start at cycle 0, then expect mem[0..len-1] in order with last on the
    // final sample and done exactly one cycle after the final handshake.
    task automatic apply_stimulus(input int len, input int ready_mode, input int abort_after, input int restart_at);
        int          got         = 0;
        int          final_hs    = -1;
        int          first_valid = -1;
        int          budget;
        bit          held        = 1'b0;
        logic [15:0] held_data   = '0;
        logic        held_last   = 1'b0;
        bit          do_abort    = 1'b0;
        bit          done_seen   = 1'b0;
        budget = 8 * len + 40;

        start_in         = 1'b1;
        ref_len_in       = 32'(len);
        ref_load_done_in = 1'b1;
        bus.ref_ready_in = pick_ready(ready_mode, 0);
        tick();
        start_in   = 1'b0;
        ref_len_in = 32'(len + 7);

        for (int cyc = 1; cyc <= budget && !done_seen; cyc++) begin
            bit rdy;
            if (do_abort) begin
                abort_in = 1'b1;
                tick();
                abort_in = 1'b0;
                check_quiet("abort_next", 1'b0);
                for (int k = 0; k < 2; k++) begin
                    tick();
                    check_quiet("abort_after", 1'b0);
                end
                return;
            end
            rdy              = pick_ready(ready_mode, cyc);
            bus.ref_ready_in = rdy;
            start_in         = (cyc == restart_at) && (final_hs < 0);

            if (held) begin
                check_output("stall_valid", 64'(bus.ref_valid_out), 64'(1));
                check_output("stall_data",  64'(bus.ref_data_out),  64'(held_data));
                check_output("stall_last",  64'(bus.ref_last_out),  64'(held_last));
            end
            if (first_valid < 0 && bus.ref_valid_out) begin
                first_valid = cyc;
                check_output("first_valid_cycle", 64'(cyc), 64'(3));
            end
            if (final_hs >= 0 && cyc == final_hs + 1) begin
                check_output("done_pulse", 64'(done_out),          64'(1));
                check_output("done_busy",  64'(busy_out),          64'(0));
                check_output("done_state", 64'(dbg_state),         64'(0));
                check_output("done_valid", 64'(bus.ref_valid_out), 64'(0));
                done_seen = 1'b1;
            end else begin
                check_output("no_early_done", 64'(done_out), 64'(0));
                check_output("busy_in_pass",  64'(busy_out), 64'(1));
                check_output("lookahead", 64'((int'(bus.ref_addr_out) - got) <= 2), 64'(1));
            end

            if (bus.ref_valid_out && rdy) begin
                if (got < len) begin
                    check_output("beat_data", 64'(bus.ref_data_out), 64'(mem[got]));
                    check_output("beat_last", 64'(bus.ref_last_out), 64'(got == len - 1));
                end else begin
                    check_output("extra_beat", 64'(got + 1), 64'(len));
                end
                got++;
                if (got == len) final_hs = cyc;
            end
            held      = bus.ref_valid_out && !rdy;
            held_data = bus.ref_data_out;
            held_last = bus.ref_last_out;
            if (abort_after > 0 && got == abort_after) do_abort = 1'b1;
            tick();
        end
        start_in = 1'b0;
        if (!done_seen) begin
            check_output("pass_timeout_beats", 64'(got), 64'(len));
            check_output("pass_timeout_done",  64'(0),   64'(1));
        end
    endtask

    initial begin
        rst              = 1'b1;
        start_in         = 1'b0;
        abort_in         = 1'b0;
        ref_len_in       = '0;
        ref_load_done_in = 1'b0;
        bus.ref_ready_in = 1'b1;
        for (int i = 0; i < 64; i++) mem[i] = 16'h100 + 16'(i);

        // Reset state.
        repeat (3) tick();
        check_output("rst_addr",  64'(bus.ref_addr_out),  64'(0));
        check_output("rst_valid", 64'(bus.ref_valid_out), 64'(0));
        check_output("rst_data",  64'(bus.ref_data_out),  64'(0));
        check_output("rst_last",  64'(bus.ref_last_out),  64'(0));
        check_output("rst_busy",  64'(busy_out),          64'(0));
        check_output("rst_done",  64'(done_out),          64'(0));
        check_output("rst_state", 64'(dbg_state),         64'(0));
        rst = 1'b0;
        tick();

        $display("[TB] len=4 with ready held high");
        apply_stimulus(4, 0, 0, 0);

        $display("[TB] len=8 with ready pattern 1,0,0,1");
        apply_stimulus(8, 1, 0, 0);

        $display("[TB] start without a loaded reference");
        start_in = 1'b1; ref_load_done_in = 1'b0; ref_len_in = 32'd5;
        tick();
        start_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_quiet("no_ref", 1'b0);
            tick();
        end

        $display("[TB] start with zero length");
        start_in = 1'b1; ref_load_done_in = 1'b1; ref_len_in = 32'd0;
        tick();
        start_in = 1'b0;
        check_quiet("zero_len_pulse", 1'b1);
        tick();
        check_quiet("zero_len_after", 1'b0);
        tick();
        check_quiet("zero_len_after2", 1'b0);

        $display("[TB] abort after 5 beats, then len=2");
        apply_stimulus(16, 0, 5, 0);
        apply_stimulus(2, 0, 0, 0);

        $display("[TB] reset during a stalled pass");
        bus.ref_ready_in = 1'b0;
        start_in = 1'b1; ref_load_done_in = 1'b1; ref_len_in = 32'd10;
        tick();
        start_in = 1'b0;
        repeat (5) tick();
        check_output("pre_rst_valid", 64'(bus.ref_valid_out), 64'(1));
        rst = 1'b1;
        tick();
        check_output("midrst_addr",  64'(bus.ref_addr_out),  64'(0));
        check_output("midrst_valid", 64'(bus.ref_valid_out), 64'(0));
        check_output("midrst_data",  64'(bus.ref_data_out),  64'(0));
        check_output("midrst_last",  64'(bus.ref_last_out),  64'(0));
        check_output("midrst_busy",  64'(busy_out),          64'(0));
        check_output("midrst_done",  64'(done_out),          64'(0));
        check_output("midrst_state", 64'(dbg_state),         64'(0));
        rst = 1'b0;
        apply_stimulus(3, 0, 0, 0);

        $display("[TB] start pulse mid-pass is ignored");
        apply_stimulus(6, 0, 0, 3);

        $display("[TB] randomized passes");
        for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
        for (int n = 0; n < 5; n++) begin
            apply_stimulus(int'($urandom_range(1, 24)), 2, 0, int'($urandom_range(2, 6)));
        end
        apply_stimulus(20, 2, 7, 0);
        apply_stimulus(1, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
